// File: rtl/std_gray_fifo_write_ctrl_pkg.sv
// Shared types and helpers for the gray-pointer asynchronous FIFO controllers.
package std_gray_fifo_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One extra pointer bit distinguishes full from empty when addresses match.
    function automatic int pointer_width(input int address_width);
        return address_width + 1;
    endfunction

endpackage

// File: rtl/std_gray_fifo_write_ctrl_if.sv
// Write-side bus of the async FIFO controller: push handshake, RAM port, pointers and flags.
interface std_gray_fifo_write_ctrl_if #(
    parameter int ADDRESS_WIDTH = 4
);
    import std_gray_fifo_pkg::*;

    localparam int PW = pointer_width(ADDRESS_WIDTH);

    // Handshake: a write is accepted in any cycle where i_push and o_ready are both high;
    // i_push may be held across stalls and o_ready never depends combinationally on i_push.
    logic                     i_push;
    logic                     o_ready;
    logic                     o_write_enable;
    logic [ADDRESS_WIDTH-1:0] o_write_address;
    logic [PW-1:0]            o_write_pointer;
    logic [PW-1:0]            i_read_pointer;
    logic                     o_full;
    logic                     o_almost_full;
    logic [PW-1:0]            o_word_count;
    state_t                   o_state;

    modport master (
        output i_push, i_read_pointer,
        input  o_ready, o_write_enable, o_write_address, o_write_pointer,
        input  o_full, o_almost_full, o_word_count, o_state
    );

    modport slave (
        input  i_push, i_read_pointer,
        output o_ready, o_write_enable, o_write_address, o_write_pointer,
        output o_full, o_almost_full, o_word_count, o_state
    );

endinterface

// File: rtl/std_gray_counter.sv
// Binary-backed counter with a registered gray output and its combinational next value.
module std_gray_counter #(
    parameter int WIDTH       = 4,
    parameter bit WRAP_AROUND = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_up,
    input  logic             i_down,
    input  logic             i_clear,
    input  logic             i_set,
    output logic [WIDTH-1:0] o_count,
    output logic [WIDTH-1:0] o_count_next
);
    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic [WIDTH-1:0] w_bin_next;

    always_comb begin
        w_bin_next = r_bin;
        if (i_clear) begin
            w_bin_next = '0;
        end else if (i_set) begin
            w_bin_next = MAX;
        end else if (i_up && !i_down) begin
            if (WRAP_AROUND || (r_bin != MAX)) w_bin_next = r_bin + WIDTH'(1);
        end else if (i_down && !i_up) begin
            if (WRAP_AROUND || (r_bin != '0)) w_bin_next = r_bin - WIDTH'(1);
        end
    end

    assign o_count_next = w_bin_next ^ (w_bin_next >> 1);
    assign o_count      = r_gray;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bin  <= '0;
            r_gray <= '0;
        end else begin
            r_bin  <= w_bin_next;
            r_gray <= o_count_next;
        end
    end

endmodule

// File: rtl/std_gray_decoder.sv
// Combinational gray-to-binary conversion.
module std_gray_decoder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_binary
);
    always_comb begin
        o_binary = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_binary[i] = ^(i_gray >> i);
        end
    end

endmodule

// File: rtl/std_gray_fifo_write_ctrl_pointer_sync.sv
// Multi-flop synchronizer for a gray pointer arriving from the opposite clock domain.
module std_gray_pointer_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);
    logic [STAGES-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_stage[STAGES-1];

endmodule

// File: rtl/std_gray_fifo_write_ctrl.sv
// Write-domain pointer controller of an async FIFO: gray write pointer, synchronized
// read pointer, RAM write strobe/address and registered full/almost-full/occupancy.
module std_gray_fifo_write_ctrl
    import std_gray_fifo_pkg::*;
#(
    parameter int          ADDRESS_WIDTH         = 4,
    parameter int          SYNC_STAGES           = 2,
    parameter int unsigned ALMOST_FULL_THRESHOLD = (2 ** ADDRESS_WIDTH) - 1
) (
    input logic                             i_clk,
    input logic                             i_rst,
    std_gray_fifo_write_ctrl_if.slave       bus
);
    localparam int PW = pointer_width(ADDRESS_WIDTH);
    localparam int CW = $clog2(SYNC_STAGES);
    localparam logic [CW-1:0] INIT_LAST = CW'(SYNC_STAGES - 1);
    // Full when the pointers differ only in their two top gray bits.
    localparam logic [PW-1:0] FULL_MASK = PW'(3 << (PW - 2));

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_init_count;
    logic          w_ready;
    logic          w_accept;
    logic [PW-1:0] w_wptr_gray;
    logic [PW-1:0] w_wptr_gray_next;
    logic [PW-1:0] w_wptr_bin;
    logic [PW-1:0] w_wptr_bin_next;
    logic [PW-1:0] w_rsync_gray;
    logic [PW-1:0] w_rsync_bin;
    logic [PW-1:0] w_count_next;
    logic          w_full_next;
    logic          w_almost_next;
    logic          r_full;
    logic          r_almost_full;
    logic [PW-1:0] r_word_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= INIT;
            r_init_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == INIT) r_init_count <= r_init_count + CW'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            INIT:    if (r_init_count == INIT_LAST) w_state_next = RUN;
            RUN:     w_state_next = RUN;
            default: w_state_next = INIT;
        endcase
    end

    always_comb begin
        w_ready = (r_state == RUN) && !r_full;
    end

    assign w_accept = bus.i_push & w_ready;

    std_gray_counter #(
        .WIDTH       (PW),
        .WRAP_AROUND (1'b1)
    ) u_wptr (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_up         (w_accept),
        .i_down       (1'b0),
        .i_clear      (1'b0),
        .i_set        (1'b0),
        .o_count      (w_wptr_gray),
        .o_count_next (w_wptr_gray_next)
    );

    std_gray_pointer_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (bus.i_read_pointer),
        .o_sync  (w_rsync_gray)
    );

    std_gray_decoder #(.WIDTH(PW)) u_wptr_dec (.i_gray(w_wptr_gray),  .o_binary(w_wptr_bin));
    std_gray_decoder #(.WIDTH(PW)) u_rptr_dec (.i_gray(w_rsync_gray), .o_binary(w_rsync_bin));

    // Flags are computed from the post-edge pointer so they never lag an accepted write.
    assign w_wptr_bin_next = w_wptr_bin + PW'(w_accept);
    assign w_full_next     = (w_wptr_gray_next == (w_rsync_gray ^ FULL_MASK));
    assign w_count_next    = w_wptr_bin_next - w_rsync_bin;
    assign w_almost_next   = (32'(w_count_next) >= ALMOST_FULL_THRESHOLD);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_word_count  <= '0;
        end else begin
            r_full        <= w_full_next;
            r_almost_full <= w_almost_next;
            r_word_count  <= w_count_next;
        end
    end

    assign bus.o_ready         = w_ready;
    assign bus.o_write_enable  = w_accept;
    assign bus.o_write_address = w_wptr_bin[ADDRESS_WIDTH-1:0];
    assign bus.o_write_pointer = w_wptr_gray;
    assign bus.o_full          = r_full;
    assign bus.o_almost_full   = r_almost_full;
    assign bus.o_word_count    = r_word_count;
    assign bus.o_state         = r_state;

endmodule

// File: tb/tb_std_gray_fifo_write_ctrl.sv
// Directed bench for the async FIFO write controller with a write-address scoreboard.
module tb_std_gray_fifo_write_ctrl;
    import std_gray_fifo_pkg::*;

    localparam int AW = 2;

    logic clk = 1'b0;
    logic rst;

    int vectors     = 0;
    int miscompares = 0;

    logic [AW-1:0] exp_q[$];
    int            wr_bin  = 0;
    int            strobes = 0;
    int            wraps   = 0;
    int            rd_bin  = 0;
    int            guard   = 0;
    logic [AW:0]   prev_wptr = '0;

    std_gray_fifo_write_ctrl_if #(.ADDRESS_WIDTH(AW)) bus();

    std_gray_fifo_write_ctrl #(
        .ADDRESS_WIDTH         (AW),
        .SYNC_STAGES           (2),
        .ALMOST_FULL_THRESHOLD (3)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [AW:0] gray(input int b);
        logic [AW:0] v;
        v = b[AW:0];
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, bus.o_ready, 0);
        check({tag, "_we"}, bus.o_write_enable, 0);
        check({tag, "_addr"}, bus.o_write_address, 0);
        check({tag, "_wptr"}, bus.o_write_pointer, 0);
        check({tag, "_full"}, bus.o_full, 0);
        check({tag, "_almost"}, bus.o_almost_full, 0);
        check({tag, "_count"}, bus.o_word_count, 0);
        check({tag, "_state"}, bus.o_state, INIT);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every observed write strobe consumes the oldest expected address.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (bus.o_write_enable === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("spurious_strobe", bus.o_write_enable, 0);
                end else begin
                    check("write_address", bus.o_write_address, exp_q.pop_front());
                    wr_bin = (wr_bin + 1) % 8;
                    strobes++;
                end
            end
            if (prev_wptr == 3'd4 && bus.o_write_pointer == 3'd0) wraps++;
            prev_wptr = bus.o_write_pointer;
        end else begin
            prev_wptr = '0;
        end
    end

    initial begin
        rst = 1'b1;
        bus.i_push = 1'b1;
        bus.i_read_pointer = '0;
        next_cycle();
        @(negedge clk);
        check_all_zero("reset");

        // Release with push held: two INIT cycles, then the first write.
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("init_ready", bus.o_ready, 0);
            check("init_state", bus.o_state, INIT);
            next_cycle();
        end

        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(AW'(i));
            @(negedge clk);
            check("fill_ready", bus.o_ready, 1);
            check("fill_count", bus.o_word_count, i);
            check("fill_almost", bus.o_almost_full, (i >= 3));
            check("fill_full", bus.o_full, 0);
            next_cycle();
        end

        @(negedge clk);
        check("full_flag", bus.o_full, 1);
        check("full_ready", bus.o_ready, 0);
        check("full_count", bus.o_word_count, 4);
        check("full_almost", bus.o_almost_full, 1);
        check("full_wptr", bus.o_write_pointer, 6);
        check("run_state", bus.o_state, RUN);
        next_cycle();

        // Free one slot; full must persist for the synchronizer latency.
        rd_bin = 1;
        bus.i_read_pointer = gray(rd_bin);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("full_hold", bus.o_full, 1);
            check("full_hold_wptr", bus.o_write_pointer, 6);
            next_cycle();
        end
        exp_q.push_back(AW'(0));
        @(negedge clk);
        check("freed_full", bus.o_full, 0);
        check("freed_ready", bus.o_ready, 1);
        check("freed_count", bus.o_word_count, 3);
        next_cycle();
        @(negedge clk);
        check("refull_flag", bus.o_full, 1);
        check("refull_count", bus.o_word_count, 4);
        next_cycle();

        // Streaming burst across the pointer wrap with the reader trailing.
        for (int i = 0; i < 20; i++) exp_q.push_back(AW'(5 + i));
        guard = 0;
        while (strobes < 25 && guard < 200) begin
            if (rd_bin != (wr_bin + 7) % 8) rd_bin = (rd_bin + 1) % 8;
            bus.i_read_pointer = gray(rd_bin);
            @(negedge clk);
            check("burst_count_le_depth", (bus.o_word_count <= 4), 1);
            check("burst_full_vs_count", bus.o_full, (bus.o_word_count == 4));
            check("burst_almost_vs_count", bus.o_almost_full, (bus.o_word_count >= 3));
            check("burst_ready", bus.o_ready, !bus.o_full);
            next_cycle();
            guard++;
        end
        check("burst_done", strobes, 25);
        bus.i_push = 1'b0;
        @(negedge clk);
        check("burst_wptr", bus.o_write_pointer, gray(wr_bin));
        check("burst_wraps", wraps, 3);
        check("burst_queue_empty", exp_q.size(), 0);
        next_cycle();

        // Asynchronous reset between clock edges.
        bus.i_push = 1'b1;
        #2;
        rst = 1'b1;
        bus.i_read_pointer = '0;
        rd_bin = 0;
        #1;
        check_all_zero("async_reset");
        wr_bin = 0;
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reinit_ready", bus.o_ready, 0);
            check("reinit_we", bus.o_write_enable, 0);
            next_cycle();
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(AW'(i));
            @(negedge clk);
            check("refill_ready", bus.o_ready, 1);
            check("refill_we", bus.o_write_enable, 1);
            next_cycle();
        end

        // Read pointer lands in the write domain on the same edge as a push.
        bus.i_push = 1'b0;
        rd_bin = 1;
        bus.i_read_pointer = gray(rd_bin);
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            check("coincide_pre_count", bus.o_word_count, 3);
            check("coincide_pre_full", bus.o_full, 0);
            next_cycle();
        end
        bus.i_push = 1'b1;
        exp_q.push_back(AW'(3));
        @(negedge clk);
        check("coincide_ready", bus.o_ready, 1);
        check("coincide_push_full", bus.o_full, 0);
        next_cycle();
        bus.i_push = 1'b0;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            check("coincide_count", bus.o_word_count, 3);
            check("coincide_full", bus.o_full, 0);
            check("coincide_almost", bus.o_almost_full, 1);
            next_cycle();
        end
        check("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
